// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI transfer sequencer.
//   - APB register map of the SPI block (CR1/CR2/BR/SR/DR)
//   - SPIF bit position inside SR
//   - sequencer FSM state encoding
package spi_seq_pkg;

  localparam logic [2:0] ADDR_CR1 = 3'd0;
  localparam logic [2:0] ADDR_CR2 = 3'd1;
  localparam logic [2:0] ADDR_BR  = 3'd2;
  localparam logic [2:0] ADDR_SR  = 3'd3;
  localparam logic [2:0] ADDR_DR  = 3'd5;

  localparam int SPIF_BIT = 7;

  typedef enum logic [3:0] {
    IDLE, W_CR1, W_CR2, W_BR, WAIT_TX, W_DR, POLL, R_DR, DONE, ERR
  } seq_state_e;

endpackage

// File: rtl/spi_apb_master_if.sv
// Two-phase APB master engine.
//   req/addr/write/wdata : one-cycle request, accepted only while psel is low
//   ack                  : completion strobe, high in the cycle pready_i=1
//   rdata/err            : read data / slave error, valid with ack
//   psel_o..pwdata_o     : registered APB master outputs
//   prdata_i/pready_i/pslverr_i : APB slave response
// ack is combinational so the requester can launch the next access on the
// completion edge; psel then stays low for exactly one cycle between accesses.
module spi_apb_master_if (
  input  logic       pclk,
  input  logic       preset_n,
  input  logic       req,
  input  logic [2:0] addr,
  input  logic       write,
  input  logic [7:0] wdata,
  output logic       ack,
  output logic [7:0] rdata,
  output logic       err,
  output logic       psel_o,
  output logic       penable_o,
  output logic [2:0] paddr_o,
  output logic       pwrite_o,
  output logic [7:0] pwdata_o,
  input  logic [7:0] prdata_i,
  input  logic       pready_i,
  input  logic       pslverr_i
);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      paddr_o   <= '0;
      pwrite_o  <= 1'b0;
      pwdata_o  <= '0;
    end else if (!psel_o) begin
      // idle: launch SETUP phase
      if (req) begin
        psel_o   <= 1'b1;
        paddr_o  <= addr;
        pwrite_o <= write;
        pwdata_o <= wdata;
      end
    end else if (!penable_o) begin
      penable_o <= 1'b1;
    end else if (pready_i) begin
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
    end
  end

  assign ack   = psel_o & penable_o & pready_i;
  assign rdata = prdata_i;
  assign err   = ack & pslverr_i;

endmodule

// File: rtl/spi_xfer_sequencer.sv
// SPI transfer sequencer: APB master that programs CR1/CR2/BR once per start,
// then for each of len bytes writes DR, polls SR until SPIF, and reads DR.
//   start_i/len_i/cr1_i/cr2_i/br_i : command, sampled in IDLE on start_i
//   tx_data_i/tx_valid_i/tx_ready_o : tx byte stream (ready only in WAIT_TX)
//   rx_data_o/rx_valid_o            : rx byte stream, no backpressure
//   busy_o/done_o/err_o             : status; done/err are one-cycle pulses
//   p*_o / p*_i                     : APB master port to the SPI block
// Optional macro SPI_SEQ_TIMEOUT_EN: bounds SR polling to POLL_MAX reads
// returning SPIF=0, then aborts with err_o.
module spi_xfer_sequencer
  import spi_seq_pkg::*;
#(
  parameter int LEN_W = 8
`ifdef SPI_SEQ_TIMEOUT_EN
  , parameter int POLL_MAX = 1023
`endif
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [7:0]       cr1_i,
  input  logic [7:0]       cr2_i,
  input  logic [7:0]       br_i,
  input  logic [7:0]       tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [2:0]       paddr_o,
  output logic             pwrite_o,
  output logic             psel_o,
  output logic             penable_o,
  output logic [7:0]       pwdata_o,
  input  logic [7:0]       prdata_i,
  input  logic             pready_i,
  input  logic             pslverr_i
);

  seq_state_e       state;
  logic [LEN_W-1:0] len_q, byte_cnt, cnt_nxt;
  logic [7:0]       cr2_q, br_q;

  // request to the APB engine: one-cycle pulse, fields held until reissue
  logic             req, req_write;
  logic [2:0]       req_addr;
  logic [7:0]       req_wdata;
  logic             apb_ack, apb_err;
  logic [7:0]       apb_rdata;

  assign cnt_nxt = byte_cnt + LEN_W'(1);

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int PCW = $clog2(POLL_MAX + 1);
  logic [PCW-1:0] poll_cnt, poll_nxt;
  assign poll_nxt = poll_cnt + PCW'(1);
`endif

  spi_apb_master_if u_apb (
    .pclk      (pclk),
    .preset_n  (preset_n),
    .req       (req),
    .addr      (req_addr),
    .write     (req_write),
    .wdata     (req_wdata),
    .ack       (apb_ack),
    .rdata     (apb_rdata),
    .err       (apb_err),
    .psel_o    (psel_o),
    .penable_o (penable_o),
    .paddr_o   (paddr_o),
    .pwrite_o  (pwrite_o),
    .pwdata_o  (pwdata_o),
    .prdata_i  (prdata_i),
    .pready_i  (pready_i),
    .pslverr_i (pslverr_i)
  );

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state      <= IDLE;
      len_q      <= '0;
      cr2_q      <= '0;
      br_q       <= '0;
      byte_cnt   <= '0;
      req        <= 1'b0;
      req_addr   <= '0;
      req_write  <= 1'b0;
      req_wdata  <= '0;
      tx_ready_o <= 1'b0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
      poll_cnt   <= '0;
`endif
    end else begin
      req        <= 1'b0;
      rx_valid_o <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      // a slave error on any access aborts; the access is already complete
      if (apb_err) begin
        state <= ERR;
        err_o <= 1'b1;
      end else begin
        case (state)
          IDLE: if (start_i) begin
            len_q     <= len_i;
            cr2_q     <= cr2_i;
            br_q      <= br_i;
            byte_cnt  <= '0;
            busy_o    <= 1'b1;
            state     <= W_CR1;
            req       <= 1'b1;
            req_addr  <= ADDR_CR1;
            req_write <= 1'b1;
            req_wdata <= cr1_i;
          end
          W_CR1: if (apb_ack) begin
            state     <= W_CR2;
            req       <= 1'b1;
            req_addr  <= ADDR_CR2;
            req_wdata <= cr2_q;
          end
          W_CR2: if (apb_ack) begin
            state     <= W_BR;
            req       <= 1'b1;
            req_addr  <= ADDR_BR;
            req_wdata <= br_q;
          end
          W_BR: if (apb_ack) begin
            if (len_q == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state      <= WAIT_TX;
              tx_ready_o <= 1'b1;
            end
          end
          WAIT_TX: if (tx_valid_i) begin
            tx_ready_o <= 1'b0;
            state      <= W_DR;
            req        <= 1'b1;
            req_addr   <= ADDR_DR;
            req_write  <= 1'b1;
            req_wdata  <= tx_data_i;
          end
          W_DR: if (apb_ack) begin
            state     <= POLL;
            req       <= 1'b1;
            req_addr  <= ADDR_SR;
            req_write <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
            poll_cnt  <= '0;
`endif
          end
          POLL: if (apb_ack) begin
            if (apb_rdata[SPIF_BIT]) begin
              state    <= R_DR;
              req      <= 1'b1;
              req_addr <= ADDR_DR;
            end else begin
`ifdef SPI_SEQ_TIMEOUT_EN
              poll_cnt <= poll_nxt;
              if (poll_nxt == PCW'(POLL_MAX)) begin
                state <= ERR;
                err_o <= 1'b1;
              end else begin
                req <= 1'b1;
              end
`else
              req <= 1'b1;  // address fields still hold SR
`endif
            end
          end
          R_DR: if (apb_ack) begin
            rx_data_o  <= apb_rdata;
            rx_valid_o <= 1'b1;
            byte_cnt   <= cnt_nxt;
            if (cnt_nxt == len_q) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state      <= WAIT_TX;
              tx_ready_o <= 1'b1;
            end
          end
          DONE, ERR: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
